// File: rtl/prng_mmio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prng_mmio_pkg
//  Purpose  : Register offsets, FSM encodings and CTRL status layout shared
//             by the PRNG MMIO peripheral.
//  Revision : 1.0 - initial release
// ============================================================================
package prng_mmio_pkg;

    localparam logic [1:0] c_reg_data    = 2'd0;
    localparam logic [1:0] c_reg_bounded = 2'd1;
    localparam logic [1:0] c_reg_limit   = 2'd2;
    localparam logic [1:0] c_reg_ctrl    = 2'd3;

    localparam int c_ctrl_seeding_bit = 8;
    localparam int c_ctrl_level_lsb   = 0;
    localparam int c_ctrl_level_w     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2,
        S_WAIT  = 2'd3
    } seed_state_t;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_POP  = 2'd1,
        B_MUL  = 2'd2,
        B_DONE = 2'd3
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/prng_mmio_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prng_fifo
//  Purpose  : DEPTH x 32 synchronous FIFO with push, pop, flush and level.
//  Revision : 1.0 - initial release
// ============================================================================
module prng_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   pop_data,
    input  logic          flush,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
            else if (!w_do_push && w_do_pop) r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/prng_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prng_mmio
//  Purpose  : CPU-facing MMIO front end for a Mersenne Twister stream:
//             word buffering, raw/bounded reads and reseed sequencing.
//  Revision : 1.0 - initial release
// ============================================================================
module prng_mmio
    import prng_mmio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    input  logic [31:0] prng_tdata,
    input  logic        prng_tvalid,
    output logic        prng_tready,
    input  logic        prng_busy,
    output logic [31:0] seed_val,
    output logic        seed_start
);
    seed_state_t   r_seed_state, w_seed_next;
    bus_state_t    r_bus_state,  w_bus_next;

    logic [31:0]   r_limit;
    logic [31:0]   r_seed_val;
    logic [31:0]   r_rdata;
    logic          r_tready;
    logic          r_bounded;
    logic [63:0]   r_acc;
    logic [63:0]   r_mcand;
    logic [31:0]   r_mplier;
    logic [4:0]    r_cnt;

    logic          w_push, w_pop, w_flush, w_full, w_empty;
    logic [31:0]   w_fifo_data;
    logic [LW-1:0] w_level, w_level_next;
    logic          w_ctrl_wr, w_limit_wr, w_pop_bounded, w_rdata_en, w_mul_start;
    logic [31:0]   w_rdata_val;
    logic [31:0]   w_status;
    logic [63:0]   w_acc_sum;
    logic          w_seeding;

    assign w_seeding   = (r_seed_state != S_IDLE);
    assign w_flush     = w_ctrl_wr;
    // Beats arriving while seeding are consumed and dropped, never buffered
    assign w_push      = prng_tvalid && r_tready && !w_seeding;
    assign w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

    assign bus_rdata   = r_rdata;
    assign bus_ready   = (r_bus_state == B_DONE);
    assign prng_tready = r_tready;
    assign seed_val    = r_seed_val;
    assign seed_start  = (r_seed_state == S_PULSE);

    prng_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (prng_tdata),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .flush     (w_flush),
        .level     (w_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_status = '0;
        w_status[c_ctrl_seeding_bit] = w_seeding;
        w_status[c_ctrl_level_lsb +: c_ctrl_level_w] = c_ctrl_level_w'(w_level);
    end

    // Bus FSM: one access at a time, completion signalled from B_DONE
    always_comb begin
        w_bus_next    = r_bus_state;
        w_pop         = 1'b0;
        w_ctrl_wr     = 1'b0;
        w_limit_wr    = 1'b0;
        w_pop_bounded = r_bounded;
        w_rdata_en    = 1'b0;
        w_rdata_val   = r_rdata;
        w_mul_start   = 1'b0;
        case (r_bus_state)
            B_IDLE: begin
                if (bus_cs) begin
                    w_pop_bounded = (bus_addr == c_reg_bounded);
                    if (bus_we) begin
                        w_ctrl_wr  = (bus_addr == c_reg_ctrl);
                        w_limit_wr = (bus_addr == c_reg_limit);
                        w_bus_next = B_DONE;
                    end else if (bus_addr == c_reg_data || bus_addr == c_reg_bounded) begin
                        w_pop      = !w_empty;
                        w_bus_next = B_POP;
                    end else begin
                        w_rdata_en  = 1'b1;
                        w_rdata_val = (bus_addr == c_reg_limit) ? r_limit : w_status;
                        w_bus_next  = B_DONE;
                    end
                end
            end
            B_POP: begin
                w_pop = !w_empty;
            end
            B_MUL: begin
                if (r_cnt == 5'd31) begin
                    w_rdata_en  = 1'b1;
                    w_rdata_val = w_acc_sum[63:32];
                    w_bus_next  = B_DONE;
                end
            end
            B_DONE: begin
                w_bus_next = B_IDLE;
            end
            default: begin
                w_bus_next = B_IDLE;
            end
        endcase
        if (w_pop) begin
            if (w_pop_bounded) begin
                w_mul_start = 1'b1;
                w_bus_next  = B_MUL;
            end else begin
                w_rdata_en  = 1'b1;
                w_rdata_val = w_fifo_data;
                w_bus_next  = B_DONE;
            end
        end
    end

    // Seed FSM: S_HOLD absorbs the one-cycle lag of the registered busy flag
    always_comb begin
        w_seed_next = r_seed_state;
        case (r_seed_state)
            S_IDLE:  w_seed_next = S_IDLE;
            S_PULSE: w_seed_next = S_HOLD;
            S_HOLD:  w_seed_next = S_WAIT;
            S_WAIT:  if (!prng_busy) w_seed_next = S_IDLE;
            default: w_seed_next = S_IDLE;
        endcase
        if (w_ctrl_wr) w_seed_next = S_PULSE;
    end

    always_comb begin
        w_level_next = w_level;
        if (w_flush)              w_level_next = '0;
        else if (w_push && !w_pop) w_level_next = w_level + LW'(1);
        else if (!w_push && w_pop) w_level_next = w_level - LW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seed_state <= S_IDLE;
            r_bus_state  <= B_IDLE;
            r_limit      <= '0;
            r_seed_val   <= '0;
            r_rdata      <= '0;
            r_tready     <= 1'b0;
            r_bounded    <= 1'b0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
        end else begin
            r_seed_state <= w_seed_next;
            r_bus_state  <= w_bus_next;
            // Registered ready looks one cycle ahead so a full FIFO never sees a beat
            r_tready     <= (w_seed_next != S_IDLE) || (w_level_next != LW'(DEPTH));
            if (w_ctrl_wr)  r_seed_val <= bus_wdata;
            if (w_limit_wr) r_limit    <= bus_wdata;
            if (w_rdata_en) r_rdata    <= w_rdata_val;
            if (r_bus_state == B_IDLE && bus_cs) r_bounded <= (bus_addr == c_reg_bounded);
            if (w_mul_start) begin
                r_acc    <= '0;
                r_mcand  <= {32'b0, w_fifo_data};
                r_mplier <= r_limit;
                r_cnt    <= '0;
            end else if (r_bus_state == B_MUL) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 5'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/prng_mmio.md
Name: prng_mmio

Overview:
- CPU-facing memory-mapped peripheral that consumes the Mersenne Twister PRNG's 32-bit AXI-stream output and feeds its seed interface.
- Buffers generated words in a small FIFO, serves raw or range-bounded random words to the RISC-V core, and sequences reseeding.
- Sits between the SoC bus decoder and the prng instance.

Parameters:
- DEPTH, 4, FIFO depth in words, power of two, 2..16.
- LW, 3, FIFO level width; must equal clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- bus_cs  in  1  access request; held until bus_ready
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  2  word select (byte addr[3:2])
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid while bus_ready=1
- bus_ready  out  1  one-cycle access-complete pulse
- prng_tdata  in  32  PRNG stream data
- prng_tvalid  in  1  PRNG stream valid
- prng_tready  out  1  PRNG stream ready
- prng_busy  in  1  PRNG seeding in progress
- seed_val  out  32  seed to PRNG
- seed_start  out  1  one-cycle seed pulse

Behaviour:
- Reset values: bus_rdata=0, bus_ready=0, prng_tready=0, seed_val=0, seed_start=0. FIFO empty, LIMIT=0, both FSMs idle.
- Register map:
  - 0 DATA (RO): pop, return raw word.
  - 1 BOUNDED (RO): pop word w, return (w*LIMIT)>>32.
  - 2 LIMIT (RW).
  - 3 CTRL: write = reseed with wdata. Read returns {23'b0, seeding, 4'b0, level[3:0]}, level zero-extended.
- Writes to 0/1 are ignored. Every access completes.
- Stream accept: a beat is taken when prng_tvalid && prng_tready.
- Seed FSM states:
  - S_IDLE: prng_tready = !full. Accepted beats are pushed to the FIFO.
  - CTRL write → S_PULSE: seed_val<=wdata; seed_start=1 for exactly this cycle; FIFO flushed to level 0.
  - S_PULSE → S_HOLD (1 cycle; covers the registered prng_busy) → S_WAIT. Exit S_WAIT to S_IDLE on the first cycle prng_busy==0.
  - In all S_* seed states prng_tready=1 and accepted beats are discarded. This drains any stale pre-seed word.
  - "seeding" status bit = 1 in any non-S_IDLE seed state.
- Bus FSM states:
  - B_IDLE → B_POP on cs and read of DATA/BOUNDED.
  - B_POP waits while the FIFO is empty (including during seeding), then pops.
  - Reads of LIMIT/CTRL and all writes: bus_ready exactly 1 cycle after cs is first sampled.
  - DATA read, FIFO non-empty at cycle 0: pop at cycle 0, bus_ready at cycle 1.
  - BOUNDED read: pop at cycle 0 (or first non-empty cycle). B_MUL runs a 32-iteration shift-add of w by LIMIT into a 64-bit accumulator, one bit per cycle. bus_ready comes 33 cycles after the pop with rdata=acc[63:32].
  - B_DONE drives bus_ready for 1 cycle, then returns to B_IDLE. cs is ignored in B_DONE.
- Boundary conditions:
  - Simultaneous push and pop: both occur, level unchanged.
  - Push when full: impossible, since tready=0.
  - Pop and flush in the same cycle: not possible (single master, access serialised). Flush wins for the level.
  - Pointers wrap modulo DEPTH.
  - LIMIT=0 → BOUNDED returns 0. LIMIT=0xFFFFFFFF → returns w-1 for w>0, and 0 for w=0.
  - rst mid-operation (seeding or multiply) returns everything to reset values immediately. Any pending access is abandoned without bus_ready.

Decomposition:
- Shared package: register offsets (DATA/BOUNDED/LIMIT/CTRL), seed FSM state encoding, bus FSM state encoding, CTRL status bit positions.
- One natural sub-module: prng_fifo (DEPTH x 32 synchronous FIFO with push, pop, flush, level, full, empty).
- The multiplier stays inline.

Test Plan:
- Bench instantiates real prng. Write CTRL=5489, then read DATA twice → 0xD091BB5C, then 0x22AE9EF6. During seeding, CTRL read shows bit 8=1. seed_start pulses exactly once.
- After reset, idle 200 cycles with no access → CTRL read level=4. prng_tready=0 while full.
- Reseed 5489, write LIMIT=6, read BOUNDED twice → 4, then 0. Each bus_ready lands exactly 33 cycles after its pop.
- Reseed 5489, fill FIFO, write CTRL=5489 again → level reads 0 after the write. The next DATA read is 0xD091BB5C (stale word drained, not returned).
- Read DATA issued in the same cycle as seeding starts → bus_ready held off until seeding ends; returns the first post-seed word.
- Assert rst during B_MUL and during S_WAIT → all outputs at reset values the same cycle, level 0, no bus_ready.
